// File: rtl/wide_fifo_pkg.sv
// Shared sizing helpers for wide_sync_fifo: lane split and count width.
package wide_fifo_pkg;

    function automatic int lane_count(input int dsize, input int lane);
        return (dsize + lane - 1) / lane;
    endfunction

    function automatic int last_lane_w(input int dsize, input int lane);
        return dsize - (lane_count(dsize, lane) - 1) * lane;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(512);

endpackage

// File: rtl/wide_fifo_lane.sv
// One lane slice of the wide FIFO: simple dual-port memory, sync write, async read.
module wide_fifo_lane #(
    parameter int WIDTH = 72,
    parameter int AW    = 9
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Storage is deliberately left without reset; the pointers define validity.
    logic [WIDTH-1:0] mem_q [2**AW];

    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wide_sync_fifo.sv
// Wide synchronous FIFO built from word-aligned lane slices under common pointers.
// Define WIDE_SYNC_FIFO_ERR_EN to enable the sticky overflow/underflow flags.
module wide_sync_fifo
    import wide_fifo_pkg::*;
#(
    parameter int DSIZE  = 1024,
    parameter int DEPTH  = 512,
    parameter int LANE   = 72,
    parameter int FWFT   = 1,
    parameter int AF_LVL = DEPTH - 16,
    parameter int AE_LVL = 16
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic [DSIZE-1:0]             din,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [DSIZE-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int NL     = lane_count(DSIZE, LANE);
    localparam int LAST_W = last_lane_w(DSIZE, LANE);
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = cnt_width(DEPTH);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_bad_depth
        $error("wide_sync_fifo: DEPTH must be a power of two >= 4");
    end
    if (AE_LVL >= AF_LVL) begin : g_bad_levels
        $error("wide_sync_fifo: AE_LVL must be below AF_LVL");
    end
    if (DSIZE < 8) begin : g_bad_dsize
        $error("wide_sync_fifo: DSIZE must be at least 8");
    end

    logic             run_q;
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic [DSIZE-1:0] dout_q, dout_d, rdata;
    logic [AW-1:0]    raddr;
    logic             wr_acc, rd_acc;

    always_comb begin
        wr_acc   = run_q & wr_en & ~full_q;
        rd_acc   = run_q & rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + CW'(wr_acc);
        rd_ptr_d = rd_ptr_q + CW'(rd_acc);
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        af_d     = (count_d >= CW'(AF_LVL));
        ae_d     = (count_d <= CW'(AE_LVL));
        raddr    = (FWFT != 0) ? rd_ptr_d[AW-1:0] : rd_ptr_q[AW-1:0];
        dout_d   = dout_q;
        // FWFT preloads the next head; when the only remaining word is being written now, bypass din.
        if (FWFT != 0) begin
            if (!empty_d) dout_d = (count_q == CW'(rd_acc)) ? din : rdata;
        end else if (rd_acc) begin
            dout_d = rdata;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            dout_q   <= '0;
        end else begin
            run_q    <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            dout_q   <= dout_d;
        end
    end

    for (genvar i = 0; i < NL; i++) begin : g_lane
        localparam int W = (i == NL - 1) ? LAST_W : LANE;
        wide_fifo_lane #(.WIDTH(W), .AW(AW)) u_lane (
            .clock (clock),
            .we    (wr_acc),
            .waddr (wr_ptr_q[AW-1:0]),
            .wdata (din[i*LANE +: W]),
            .raddr (raddr),
            .rdata (rdata[i*LANE +: W])
        );
    end

`ifdef WIDE_SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (run_q & wr_en & full_q);
        unf_d = unf_q | (run_q & rd_en & empty_q);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign dout         = dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

endmodule
